// File: rtl/bus_rr_pkg.sv
// rtl/bus_rr_pkg.sv - shared types and round-robin pick helper for bus_rr
//
// Contents:
//   state_t  : arbiter FSM states (IDLE, GRANT)
//   rsel_t   : registered read-select {valid, idx}
//   pick_t   : result of rr_pick {found, idx}
//   rr_pick  : first requester after a pointer, scanning modulo n
package bus_rr_pkg;

   localparam int MAX_M      = 8;   // widest master count supported
   localparam int MAX_SIDX_W = 8;   // widest slave index carried in rsel_t

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic [MAX_SIDX_W-1:0] idx;
   } rsel_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // Scans ptr+1, ptr+2, ... ptr+n (mod n). The scan runs from the far end
   // back toward ptr+1 so that the nearest requester is the last to be
   // written and therefore wins.
   function automatic pick_t rr_pick(input logic [MAX_M-1:0] req,
                                     input logic [2:0]       ptr,
                                     input int               n);
      pick_t r;
      int    cand;
      r = '0;
      for (int k = MAX_M; k >= 1; k--) begin
         if (k <= n) begin
            cand = (int'(ptr) + k) % n;
            if (req[cand]) begin
               r.found = 1'b1;
               r.idx   = 3'(cand);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - registered round-robin arbiter for bus_rr
//
// Optional feature macro: BUS_RR_HOLD_LIMIT_EN (grant hold limit of MAX_HOLD cycles)
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   m_req       in   per-master request
//   m_grant     out  one-hot or zero grant
//   grant_idx   out  index of the granted master (meaningful when grant_valid)
//   grant_valid out  high in GRANT state
module bus_rr_arbiter
   import bus_rr_pkg::*;
#(
   parameter int NUM_M    = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_M-1:0]         m_req,
   output logic [NUM_M-1:0]         m_grant,
   output logic [$clog2(NUM_M)-1:0] grant_idx,
   output logic                     grant_valid
);

   localparam int IW = $clog2(NUM_M);

   state_t          state_q, state_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [IW-1:0]   last_q, last_d;
   logic [MAX_M-1:0] req_ext;
   logic [NUM_M-1:0] own_mask;
   logic            other_req;
   logic            hold_expired;
   logic            new_grant;
   pick_t           pk;

   always_comb begin
      req_ext = '0;
      req_ext[NUM_M-1:0] = m_req;
      own_mask = '0;
      own_mask[gidx_q] = 1'b1;
      other_req = |(m_req & ~own_mask);
   end

`ifdef BUS_RR_HOLD_LIMIT_EN
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   logic [HW-1:0] hold_q, hold_d;

   // Counts cycles of the current grant; saturates so a lone owner never wraps.
   always_comb begin
      hold_d = hold_q;
      if (new_grant) begin
         hold_d = '0;
      end else if (state_q == GRANT && hold_q != HW'(MAX_HOLD - 1)) begin
         hold_d = hold_q + 1'b1;
      end
      hold_expired = (state_q == GRANT) && (hold_q == HW'(MAX_HOLD - 1)) && other_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   // MAX_HOLD is at least 1, so this is constant low: the owner keeps the bus.
   always_comb begin
      hold_expired = (MAX_HOLD == 0) && other_req;
   end
`endif

   always_comb begin
      state_d   = state_q;
      gidx_d    = gidx_q;
      last_d    = last_q;
      new_grant = 1'b0;
      // In GRANT last_q equals gidx_q, so one scan from last_q serves both states.
      pk = rr_pick(req_ext, 3'(last_q), NUM_M);
      if (state_q == GRANT && m_req[gidx_q] && !hold_expired) begin
         state_d = GRANT;
      end else if (pk.found) begin
         state_d   = GRANT;
         gidx_d    = IW'(pk.idx);
         last_d    = IW'(pk.idx);
         new_grant = 1'b1;
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gidx_q  <= '0;
         last_q  <= IW'(NUM_M - 1);
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      m_grant = '0;
      if (state_q == GRANT) begin
         m_grant[gidx_q] = 1'b1;
      end
      grant_idx   = gidx_q;
      grant_valid = (state_q == GRANT);
   end

endmodule

// File: rtl/bus_rr.sv
// rtl/bus_rr.sv - round-robin shared bus, NUM_M masters to NUM_S slaves
//
// Optional feature macro: BUS_RR_HOLD_LIMIT_EN (grant hold limit, see bus_rr_arbiter)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   m_req      in   per-master request
//   m_wr       in   per-master write enable
//   m_address  in   master i address at [i*AW +: AW]
//   m_dout     in   master i write data at [i*DW +: DW]
//   s_dout     in   slave j read data at [j*DW +: DW]
//   m_grant    out  one-hot or zero grant
//   m_din      out  read data broadcast to masters, one cycle after address phase
//   s_sel      out  one-hot or zero slave select
//   s_address  out  muxed address
//   s_wr       out  muxed write enable (suppressed for unmapped addresses)
//   s_din      out  muxed write data
module bus_rr
   import bus_rr_pkg::*;
#(
   parameter int NUM_M    = 4,
   parameter int NUM_S    = 4,
   parameter int AW       = 8,
   parameter int DW       = 32,
   parameter int SIDX_W   = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_M-1:0]    m_req,
   input  logic [NUM_M-1:0]    m_wr,
   input  logic [NUM_M*AW-1:0] m_address,
   input  logic [NUM_M*DW-1:0] m_dout,
   input  logic [NUM_S*DW-1:0] s_dout,
   output logic [NUM_M-1:0]    m_grant,
   output logic [DW-1:0]       m_din,
   output logic [NUM_S-1:0]    s_sel,
   output logic [AW-1:0]       s_address,
   output logic                s_wr,
   output logic [DW-1:0]       s_din
);

   logic [$clog2(NUM_M)-1:0] grant_idx;
   logic                     grant_valid;
   logic [SIDX_W-1:0]        sidx;
   logic                     mapped;
   rsel_t                    rsel_q, rsel_d;

   bus_rr_arbiter #(
      .NUM_M    (NUM_M),
      .MAX_HOLD (MAX_HOLD)
   ) u_arbiter (
      .clk         (clk),
      .reset       (reset),
      .m_req       (m_req),
      .m_grant     (m_grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      s_address = '0;
      s_din     = '0;
      s_wr      = 1'b0;
      s_sel     = '0;
      if (grant_valid) begin
         s_address = m_address[int'(grant_idx)*AW +: AW];
         s_din     = m_dout[int'(grant_idx)*DW +: DW];
      end
      sidx   = s_address[AW-1 -: SIDX_W];
      mapped = grant_valid && (int'(sidx) < NUM_S);
      if (mapped) begin
         s_sel[sidx] = 1'b1;
         s_wr        = m_wr[grant_idx];
      end
      rsel_d.valid = |s_sel;
      rsel_d.idx   = MAX_SIDX_W'(sidx);
   end

   // Captured every cycle so read data follows the address phase even when
   // the grant moves at the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsel_q <= '0;
      end else begin
         rsel_q <= rsel_d;
      end
   end

   always_comb begin
      m_din = '0;
      if (rsel_q.valid) begin
         m_din = s_dout[int'(rsel_q.idx)*DW +: DW];
      end
   end

endmodule

// File: doc/bus_rr.md
# bus_rr

Parametrised shared-bus interconnect connecting NUM_M masters to NUM_S slaves over one address/data path. A registered round-robin arbiter grants the bus to one master at a time. An address decoder selects the target slave, and a registered read-select returns slave read data to the masters one cycle after the address phase. It succeeds the fixed two-master/two-slave bus and sits between the processor/DMA masters and the memory-mapped slaves.

## Interface
- NUM_M, 4, number of masters (2..8)
- NUM_S, 4, number of slaves (1..2^SIDX_W)
- AW, 8, address width
- DW, 32, data width
- SIDX_W, 2, upper address bits used as slave index; s_address[AW-1 -: SIDX_W]
- MAX_HOLD, 16, grant hold limit in cycles; used only with BUS_RR_HOLD_LIMIT_EN
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m_req  in  NUM_M  per-master bus request
- m_wr  in  NUM_M  per-master write enable
- m_address  in  NUM_M*AW  master i address at [i*AW +: AW]
- m_dout  in  NUM_M*DW  master i write data at [i*DW +: DW]
- s_dout  in  NUM_S*DW  slave j read data at [j*DW +: DW]
- m_grant  out  NUM_M  one-hot or zero grant
- m_din  out  DW  read data broadcast to all masters
- s_sel  out  NUM_S  one-hot or zero slave select
- s_address  out  AW  muxed address
- s_wr  out  1  muxed write enable
- s_din  out  DW  muxed write data

## Operation
- Arbiter states: IDLE (m_grant = 0) and GRANT (exactly one m_grant bit set). State, grant index and last-granted pointer are registered.
- Transitions out of IDLE:
  - No requests: stay in IDLE.
  - Any m_req: go to GRANT for the first requester scanning last+1, last+2, … modulo NUM_M.
- Transitions out of GRANT(i):
  - m_req[i] high: hold GRANT(i).
  - m_req[i] low and another master requesting: move directly to the next requester by round-robin from i+1. No idle cycle.
  - m_req[i] low and no other request: go to IDLE.
- The last-granted pointer updates on every new grant. It resets to NUM_M-1, so master 0 has first priority after reset.
- Forward path is combinational from the grant:
  - In GRANT(i), s_address/s_wr/s_din carry master i's signals.
  - In IDLE, all three are 0.
- Decoder: idx = s_address[AW-1 -: SIDX_W].
  - s_sel[idx] = 1 only when in GRANT and idx < NUM_S.
  - Otherwise s_sel = 0. An unmapped address never writes.
- Read return: a registered rsel captures {valid, idx} every cycle. valid = (s_sel != 0).
  - m_din = s_dout[rsel.idx] when rsel.valid, else 0.
- All outputs are 0 after reset: m_grant, s_sel, s_wr, s_address, s_din, m_din.

## Timing
- Request latency: m_req rising before edge t → m_grant high after edge t.
- Address phase: the cycle in which m_grant[i] is high.
- Read latency: address phase in cycle k → m_din valid in cycle k+1, even if the grant changed at edge k.
- Handover between two masters: 0 idle cycles.
- A master dropping m_req in its last address cycle loses the grant at the next edge.
- Simultaneous requests resolve by round-robin order only. There is no fixed priority beyond the pointer.
- Reset asserted mid-transfer: all state clears immediately (asynchronous). m_din = 0 until the first post-reset address phase completes.

## Configuration
- Macro: BUS_RR_HOLD_LIMIT_EN.
- Defined:
  - A hold counter of clog2(MAX_HOLD) bits counts cycles of the current grant and clears on each new grant.
  - When the count reaches MAX_HOLD-1 and another master is requesting, the grant rotates at the next edge even though the current owner still requests.
  - The preempted master re-arbitrates normally.
- Undefined: a grant is held for as long as the owner requests. No counter logic is present.

## Structure
- Package bus_rr_pkg:
  - rsel struct {valid, idx[SIDX_W]}
  - state enum {IDLE, GRANT}
  - round-robin pick function: request vector + pointer → index + found flag
- Sub-module bus_rr_arbiter:
  - Holds the FSM, pointer and optional hold counter.
  - Outputs m_grant and the grant index.
- Muxing, decode and rsel register stay in bus_rr.

## Test plan
- Reset, then m_req = 0001 with m0 address 0x40, wr = 1 → m_grant = 0001 after one edge; s_sel = 0010; s_wr = 1; s_din = m0_dout.
- m_req = 1111 held, each master dropping req after 1 cycle → grant order m0, m1, m2, m3, m0 with no gaps.
- Read from m2 at address 0x80, s_dout[2] = 0xDEADBEEF → m_din = 0xDEADBEEF exactly one cycle after the address phase; 0 before it.
- NUM_S = 3, address 0xC0 → s_sel = 0, s_wr suppressed, m_din = 0 the next cycle.
- BUS_RR_HOLD_LIMIT_EN with MAX_HOLD = 4, m0 and m1 both requesting continuously → grant alternates every 4 cycles. Without the macro, m0 keeps the grant indefinitely.
- Reset asserted while m1 is granted mid-read → m_grant, s_sel and m_din are 0 immediately. After release, m0 is granted first if both request.
